core_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32 core. Drives cpu_state (consumed by pc, IR, regfile, LSU),

---
 rtl/rv32_opcodes_pkg.sv | 38 +++
 rtl/core_ctrl_fsm.sv | 120 ++++++++++++
 tb/tb_core_ctrl_fsm.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_opcodes_pkg.sv
// rv32_opcodes_pkg: sequencer state codes, RV32 major opcodes and mcause codes
package rv32_opcodes_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } cpu_state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [4:0] MCAUSE_INSN_FAULT     = 5'd1;
   localparam logic [4:0] MCAUSE_ILLEGAL        = 5'd2;
   localparam logic [4:0] MCAUSE_BREAKPOINT     = 5'd3;
   localparam logic [4:0] MCAUSE_LOAD_MISALIGN  = 5'd4;
   localparam logic [4:0] MCAUSE_LOAD_FAULT     = 5'd5;
   localparam logic [4:0] MCAUSE_STORE_MISALIGN = 5'd6;
   localparam logic [4:0] MCAUSE_STORE_FAULT    = 5'd7;
   localparam logic [4:0] MCAUSE_ECALL_M        = 5'd11;
   localparam logic [4:0] MCAUSE_MEI            = 5'd11;

   // opcodes whose result goes through the writeback state
   function automatic logic needs_wb(input logic [6:0] op);
      return op inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM};
   endfunction

endpackage

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle RV32 sequencer with bus watchdog, trap and mret arbitration
module core_ctrl_fsm
   import rv32_opcodes_pkg::*;
#(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       illegal_insn,
   input  logic       is_ecall,
   input  logic       is_ebreak,
   input  logic       is_mret,
   input  logic       misaligned,
   input  logic       irq_pending,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic [2:0] cpu_state,
   output logic       imem_req,
   output logic       ir_we,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       rf_we,
   output logic       take_trap,
   output logic       take_return,
   output logic       trap_irq,
   output logic [4:0] trap_cause,
   output logic       retire
);

   localparam int WW = $clog2(BUS_TIMEOUT + 1);

   cpu_state_e    state, state_d;
   logic          started_q;
   logic [WW-1:0] wdog, wdog_d;
   logic [4:0]    cause_q, cause_d, exc_cause;
   logic          irq_q, irq_d;
   logic          exc, bnd, busy, timeout, mem_first, mem_op, is_store;

   assign is_store  = opcode == OPC_STORE;
   assign mem_op    = (opcode == OPC_LOAD) | is_store;
   assign busy      = ((state == ST_FETCH) & started_q) | (state == ST_MEM);
   assign timeout   = wdog == WW'(BUS_TIMEOUT);
   assign mem_first = wdog == '0;

   // state, start flag, watchdog and latched trap cause
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_FETCH;
         started_q <= 1'b0;
         wdog      <= '0;
         cause_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         state     <= state_d;
         started_q <= 1'b1;
         wdog      <= wdog_d;
         cause_q   <= cause_d;
         irq_q     <= irq_d;
      end
   end

   // next state; exceptions beat interrupts, interrupts only at instruction boundaries
   always_comb begin
      state_d   = ST_FETCH;
      exc       = 1'b0;
      exc_cause = '0;
      bnd       = 1'b0;
      case (state)
         ST_FETCH: begin
            exc       = started_q & ~imem_ready & timeout;
            exc_cause = MCAUSE_INSN_FAULT;
            state_d   = (started_q & imem_ready) ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            exc       = illegal_insn | is_ebreak | is_ecall;
            exc_cause = illegal_insn ? MCAUSE_ILLEGAL : is_ebreak ? MCAUSE_BREAKPOINT : MCAUSE_ECALL_M;
            state_d   = ST_EXEC;
         end
         ST_EXEC: begin
            state_d = is_mret ? ST_FETCH : mem_op ? ST_MEM : needs_wb(opcode) ? ST_WB : ST_FETCH;
            bnd     = is_mret | (~mem_op & ~needs_wb(opcode));
         end
         ST_MEM: begin
            exc       = (mem_first & misaligned) | (~dmem_ready & timeout);
            exc_cause = (mem_first & misaligned) ? (is_store ? MCAUSE_STORE_MISALIGN : MCAUSE_LOAD_MISALIGN)
                                                 : (is_store ? MCAUSE_STORE_FAULT : MCAUSE_LOAD_FAULT);
            state_d   = ~dmem_ready ? ST_MEM : is_store ? ST_FETCH : ST_WB;
            bnd       = dmem_ready & is_store;
         end
         ST_WB:   bnd = 1'b1;
         default: state_d = ST_FETCH;
      endcase
      cause_d = cause_q;
      irq_d   = irq_q;
      if (exc | (bnd & irq_pending)) begin
         state_d = ST_TRAP;
         cause_d = exc ? exc_cause : MCAUSE_MEI;
         irq_d   = ~exc;
      end
      wdog_d = (busy && state_d == state) ? wdog + WW'(1) : '0;
   end

   // datapath controls decoded from the current state
   always_comb begin
      cpu_state   = state;
      imem_req    = (state == ST_FETCH) & started_q;
      ir_we       = imem_req & imem_ready;
      dmem_req    = (state == ST_MEM) & ~(mem_first & misaligned);
      dmem_we     = dmem_req & is_store;
      rf_we       = state == ST_WB;
      take_trap   = state == ST_TRAP;
      trap_irq    = take_trap & irq_q;
      trap_cause  = take_trap ? cause_q : '0;
      take_return = (state == ST_EXEC) & is_mret;
      retire      = rf_we | (dmem_we & dmem_ready)
                  | ((state == ST_EXEC) & (is_mret | (~mem_op & ~needs_wb(opcode))));
   end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: scoreboard bench with a per-instruction behavioural model of the sequencer
module tb_core_ctrl_fsm;

   localparam int BT = 4;
   localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_OP = 7'b0110011,
                          O_IMM = 7'b0010011, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111,
                          O_JAL = 7'b1101111, O_JALR = 7'b1100111, O_SYS = 7'b1110011,
                          O_BR = 7'b1100011, O_FENCE = 7'b0001111, O_UNK = 7'b1111111;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [6:0] opcode = '0;
   logic illegal_insn = 0, is_ecall = 0, is_ebreak = 0, is_mret = 0, misaligned = 0;
   logic irq_pending = 0, imem_ready = 0, dmem_ready = 0;
   logic [2:0] cpu_state;
   logic imem_req, ir_we, dmem_req, dmem_we, rf_we, take_trap, take_return, trap_irq, retire;
   logic [4:0] trap_cause;

   always #5 clk = ~clk;

   core_ctrl_fsm #(.BUS_TIMEOUT(BT)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .illegal_insn(illegal_insn),
      .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret), .misaligned(misaligned),
      .irq_pending(irq_pending), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .cpu_state(cpu_state), .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .rf_we(rf_we), .take_trap(take_trap), .take_return(take_return),
      .trap_irq(trap_irq), .trap_cause(trap_cause), .retire(retire)
   );

   typedef struct packed {
      logic [2:0] st;
      logic       trap;
      logic       irq;
      logic [4:0] cause;
      logic       ret;
      logic       rtr;
      logic       rfw;
      logic       irw;
      logic       dacc;
      logic       dwe;
      logic [7:0] reqc;
   } ev_t;

   ev_t exp_q[$];
   int  n_vec = 0, n_err = 0, req_cyc = 0;

   function automatic ev_t ev_trap(input logic irq, input logic [4:0] c, input int rc);
      ev_t e = '0;
      e.st = 3'd5; e.trap = 1'b1; e.irq = irq; e.cause = c; e.reqc = 8'(rc);
      return e;
   endfunction
   function automatic ev_t ev_fetch(input int rc);
      ev_t e = '0;
      e.irw = 1'b1; e.reqc = 8'(rc);
      return e;
   endfunction
   function automatic ev_t ev_exec(input logic ret);
      ev_t e = '0;
      e.st = 3'd2; e.ret = ret; e.rtr = 1'b1;
      return e;
   endfunction
   function automatic ev_t ev_wb();
      ev_t e = '0;
      e.st = 3'd4; e.rfw = 1'b1; e.rtr = 1'b1;
      return e;
   endfunction
   function automatic ev_t ev_mem(input logic we, input int rc);
      ev_t e = '0;
      e.st = 3'd3; e.dacc = 1'b1; e.dwe = we; e.rtr = we; e.reqc = 8'(rc);
      return e;
   endfunction

   // monitor: every visible control event is popped from the scoreboard and compared
   always @(negedge clk) begin
      ev_t o, e;
      if (!rst_n) req_cyc = 0;
      else begin
         req_cyc += int'(imem_req | dmem_req);
         if (take_trap | take_return | retire | rf_we | ir_we | (dmem_req & dmem_ready)) begin
            o = '0;
            o.st = cpu_state; o.trap = take_trap; o.irq = take_trap & trap_irq;
            o.cause = take_trap ? trap_cause : 5'd0; o.ret = take_return; o.rtr = retire;
            o.rfw = rf_we; o.irw = ir_we; o.dacc = dmem_req & dmem_ready;
            o.dwe = dmem_req & dmem_ready & dmem_we; o.reqc = 8'(req_cyc);
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_event t=%0t got=%p required=none", $time, o);
            end else begin
               e = exp_q.pop_front();
               if (o !== e) begin
                  n_err++;
                  $display("FAIL event t=%0t got=%p required=%p", $time, o, e);
               end
            end
            req_cyc = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic wait_req();
      int k = 0;
      while (!imem_req && k < 20) begin
         step();
         k++;
      end
      check("wait_imem_req", 32'(imem_req), 32'd1);
      irq_pending = 1'b0;
   endtask

   task automatic wait_mem();
      int k = 0;
      while (cpu_state != 3'd3 && k < 6) begin
         step();
         k++;
      end
      check("wait_mem_state", 32'(cpu_state), 32'd3);
   endtask

   // one instruction: drive fetch/decoder/LSU inputs and push the events it must produce
   task automatic do_insn(input int kind, input int fd, input bit ftmo, input int md,
                          input bit mtmo, input bit mis, input bit irq);
      logic [6:0] op = O_IMM;
      bit ill = 0, eb = 0, ec = 0, mr = 0, st, retired = 0, drive_mem = 0;
      wait_req();
      if (ftmo) begin
         exp_q.push_back(ev_trap(1'b0, 5'd1, BT + 1));
         repeat (BT + 1) step();
         return;
      end
      case (kind)
         0: op = O_IMM;
         1: op = O_OP;
         2: op = O_LUI;
         3: op = O_AUIPC;
         4: op = O_JAL;
         5: op = O_JALR;
         6: op = O_BR;
         7: op = O_FENCE;
         8: op = O_LOAD;
         9: op = O_STORE;
         10: begin op = O_SYS; mr = 1; end
         11: begin op = O_SYS; ec = 1; end
         12: begin op = O_SYS; eb = 1; ec = 1'($urandom); end
         13: begin op = 7'($urandom); ill = 1; eb = 1'($urandom); ec = 1'($urandom); end
         14: op = O_UNK;
         default: op = O_SYS;
      endcase
      exp_q.push_back(ev_fetch(fd + 1));
      repeat (fd) step();
      opcode = op; illegal_insn = ill; is_ebreak = eb; is_ecall = ec; is_mret = mr;
      misaligned = mis; irq_pending = irq; imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      st = op == O_STORE;
      if (ill) exp_q.push_back(ev_trap(1'b0, 5'd2, 0));
      else if (eb) exp_q.push_back(ev_trap(1'b0, 5'd3, 0));
      else if (ec) exp_q.push_back(ev_trap(1'b0, 5'd11, 0));
      else if (mr) begin exp_q.push_back(ev_exec(1'b1)); retired = 1; end
      else if (op == O_LOAD || op == O_STORE) begin
         drive_mem = 1;
         if (mis) exp_q.push_back(ev_trap(1'b0, st ? 5'd6 : 5'd4, 0));
         else if (mtmo) exp_q.push_back(ev_trap(1'b0, st ? 5'd7 : 5'd5, BT + 1));
         else begin
            exp_q.push_back(ev_mem(st, md + 1));
            if (!st) exp_q.push_back(ev_wb());
            retired = 1;
         end
      end
      else if (op inside {O_OP, O_IMM, O_LUI, O_AUIPC, O_JAL, O_JALR, O_SYS}) begin
         exp_q.push_back(ev_wb());
         retired = 1;
      end
      else begin exp_q.push_back(ev_exec(1'b0)); retired = 1; end
      if (retired && irq) exp_q.push_back(ev_trap(1'b1, 5'd11, 0));
      if (drive_mem) begin
         wait_mem();
         if (!mis) begin
            if (mtmo) repeat (BT + 1) step();
            else begin
               repeat (md) step();
               dmem_ready = 1'b1;
               step();
               dmem_ready = 1'b0;
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout t=%0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      repeat (3) step();
      check("reset_outputs", 32'({cpu_state, imem_req, ir_we, dmem_req, dmem_we, rf_we, take_trap,
                                  take_return, trap_irq, trap_cause, retire}), 32'd0);
      rst_n = 1'b1;
      check("imem_req_before_start", 32'({cpu_state, imem_req}), 32'd0);
      do_insn(0, 1, 0, 0, 0, 0, 0);
      do_insn(8, 0, 0, 2, 0, 0, 0);
      do_insn(9, 0, 0, 0, 0, 1, 0);
      do_insn(0, 0, 1, 0, 0, 0, 0);
      do_insn(6, 0, 0, 0, 0, 0, 1);
      do_insn(10, 2, 0, 0, 0, 0, 0);
      do_insn(13, 0, 0, 0, 0, 0, 0);
      do_insn(9, 1, 0, 3, 0, 0, 1);
      do_insn(8, 0, 0, 0, 1, 0, 0);
      do_insn(9, 0, 0, 0, 1, 0, 0);
      do_insn(8, 0, 0, 0, 0, 1, 1);
      do_insn(11, 0, 0, 0, 0, 0, 1);
      do_insn(12, 0, 0, 0, 0, 0, 0);
      do_insn(14, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 400; i++)
         do_insn($urandom_range(15), $urandom_range(3), $urandom_range(11) == 0, $urandom_range(3),
                 $urandom_range(11) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0);
      wait_req();
      exp_q.push_back(ev_fetch(1));
      opcode = O_LOAD; illegal_insn = 0; is_ebreak = 0; is_ecall = 0; is_mret = 0; misaligned = 0;
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      wait_mem();
      step();
      #2 rst_n = 1'b0;
      #1 check("reset_in_mem", 32'({cpu_state, dmem_req, imem_req}), 32'd0);
      step();
      rst_n = 1'b1;
      do_insn(1, 1, 0, 0, 0, 0, 0);
      repeat (5) step();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
